// File: rtl/mem_pkg.sv
// rtl/mem_pkg.sv - shared memory-port constants, request type and round-robin search
package mem_pkg;

    localparam int MEM_ADDR_W = 32;
    localparam int MEM_WORD_W = 64;

    typedef struct packed {
        logic                  we;
        logic [MEM_ADDR_W-1:0] addr;
        logic [MEM_WORD_W-1:0] wdata;
    } mem_req_t;

    // First set bit of valid at or after ptr, wrapping; n is a power of two.
    // Returns ptr when nothing is valid, callers qualify with |valid.
    function automatic int unsigned rr_next(input int unsigned ptr,
                                            input logic [31:0]   valid,
                                            input int unsigned   n);
        int unsigned idx;
        rr_next = ptr;
        for (int unsigned k = n; k > 0; k--) begin
            idx = (ptr + k - 1) & (n - 1);
            if (valid[idx[4:0]]) begin
                rr_next = idx;
            end
        end
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - round-robin grant with priority pointer; optional grant lock under ARB_LOCK_EN
module rr_arbiter
    import mem_pkg::*;
#(
    parameter int NUM_CORES = 4
`ifdef ARB_LOCK_EN
    ,
    parameter int LOCK_MAX  = 8
`endif
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [NUM_CORES-1:0]         valid,
`ifdef ARB_LOCK_EN
    input  logic [NUM_CORES-1:0]         lock,
`endif
    output logic [NUM_CORES-1:0]         grant,
    output logic [$clog2(NUM_CORES)-1:0] grant_id,
    output logic                         grant_any
);

    localparam int PTR_W = $clog2(NUM_CORES);

    logic [PTR_W-1:0] ptr;
    logic [PTR_W-1:0] rr_id;

    // Round-robin candidate; nothing is granted while reset is held
    always_comb begin
        rr_id     = PTR_W'(rr_next(32'(ptr), 32'(valid), NUM_CORES));
        grant_any = (|valid) & ~reset;
    end

`ifdef ARB_LOCK_EN
    localparam int CNT_W = $clog2(LOCK_MAX + 1);

    logic             lock_hold;
    logic [PTR_W-1:0] lock_id;
    logic [CNT_W-1:0] lock_cnt;
    logic             forced;
    logic [CNT_W-1:0] run_next;

    // A held lock overrides round-robin while its owner keeps requesting
    always_comb begin
        forced   = lock_hold & valid[lock_id];
        grant_id = forced ? lock_id : rr_id;
        run_next = forced ? lock_cnt + CNT_W'(1) : CNT_W'(1);
    end

    // Track the lock owner and its run of consecutive locked grants; a full run releases it
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lock_hold <= 1'b0;
            lock_id   <= '0;
            lock_cnt  <= '0;
        end else if (grant_any && lock[grant_id] && (int'(run_next) < LOCK_MAX)) begin
            lock_hold <= 1'b1;
            lock_id   <= grant_id;
            lock_cnt  <= run_next;
        end else begin
            lock_hold <= 1'b0;
            lock_cnt  <= '0;
        end
    end
`else
    // Pure round-robin selection
    always_comb begin
        grant_id = rr_id;
    end
`endif

    // One-hot grant vector
    always_comb begin
        grant = '0;
        if (grant_any) begin
            grant[grant_id] = 1'b1;
        end
    end

    // Priority moves just past the last winner; wraps naturally for power-of-two counts
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ptr <= '0;
        end else if (grant_any) begin
            ptr <= grant_id + PTR_W'(1);
        end
    end

endmodule

// File: rtl/ram_port_arbiter.sv
// rtl/ram_port_arbiter.sv - multiplexes core requests onto one RAM port, returns responses one cycle later; ARB_LOCK_EN adds req_lock
module ram_port_arbiter
    import mem_pkg::*;
#(
    parameter int NUM_CORES = 4,
    parameter int ADDR_W    = MEM_ADDR_W,
    parameter int WORD_W    = MEM_WORD_W,
    parameter int LOCK_MAX  = 8
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [NUM_CORES-1:0]        req_valid,
    input  logic [NUM_CORES-1:0]        req_we,
    input  logic [NUM_CORES*ADDR_W-1:0] req_addr,
    input  logic [NUM_CORES*WORD_W-1:0] req_wdata,
`ifdef ARB_LOCK_EN
    input  logic [NUM_CORES-1:0]        req_lock,
`endif
    output logic [NUM_CORES-1:0]        req_ready,
    output logic [NUM_CORES-1:0]        resp_valid,
    output logic [WORD_W-1:0]           resp_rdata,
    output logic [ADDR_W-1:0]           ram_address,
    output logic [WORD_W-1:0]           ram_data,
    output logic                        ram_wren,
    input  logic [WORD_W-1:0]           ram_q
);

    localparam int ID_W = $clog2(NUM_CORES);

    if (NUM_CORES < 2 || (NUM_CORES & (NUM_CORES - 1)) != 0 || LOCK_MAX < 1) begin : g_bad_cfg
        $error("ram_port_arbiter: NUM_CORES must be a power of two >= 2 and LOCK_MAX >= 1");
    end

    logic [ID_W-1:0] grant_id;
    logic            grant_any;
    logic            pend_valid;
    logic [ID_W-1:0] pend_id;

    rr_arbiter #(
        .NUM_CORES (NUM_CORES)
`ifdef ARB_LOCK_EN
        ,
        .LOCK_MAX  (LOCK_MAX)
`endif
    ) u_arb (
        .clk       (clk),
        .reset     (reset),
        .valid     (req_valid),
`ifdef ARB_LOCK_EN
        .lock      (req_lock),
`endif
        .grant     (req_ready),
        .grant_id  (grant_id),
        .grant_any (grant_any)
    );

    // Steer the granted channel onto the RAM port; idle port is driven to zero
    always_comb begin
        ram_address = '0;
        ram_data    = '0;
        ram_wren    = 1'b0;
        if (grant_any) begin
            ram_address = req_addr[int'(grant_id)*ADDR_W +: ADDR_W];
            ram_data    = req_wdata[int'(grant_id)*WORD_W +: WORD_W];
            ram_wren    = req_we[grant_id];
        end
    end

    // Remember who was granted so the RAM's registered output can be routed back
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pend_valid <= 1'b0;
            pend_id    <= '0;
        end else begin
            pend_valid <= grant_any;
            if (grant_any) begin
                pend_id <= grant_id;
            end
        end
    end

    // Response strobe to the pending owner; data is the RAM output passed straight through
    always_comb begin
        resp_valid = '0;
        if (pend_valid) begin
            resp_valid[pend_id] = 1'b1;
        end
        resp_rdata = ram_q;
    end

endmodule

// File: tb/tb_ram_port_arbiter.sv
// tb/tb_ram_port_arbiter.sv - directed bench with reference model for ram_port_arbiter; lock vectors under ARB_LOCK_EN
module tb_ram_port_arbiter;

    localparam int NC       = 4;
    localparam int LOCK_MAX = 8;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [NC-1:0] v = '0;
    logic [NC-1:0] we = '0;
    logic [31:0]   a [NC];
    logic [63:0]   d [NC];
`ifdef ARB_LOCK_EN
    logic [NC-1:0] lk = '0;
`endif

    logic [NC*32-1:0] req_addr;
    logic [NC*64-1:0] req_wdata;
    logic [NC-1:0]    req_ready;
    logic [NC-1:0]    resp_valid;
    logic [63:0]      resp_rdata;
    logic [31:0]      ram_address;
    logic [63:0]      ram_data;
    logic             ram_wren;
    logic [63:0]      ram_q = '0;

    int n_chk = 0;
    int n_fail = 0;

    assign req_addr  = {a[3], a[2], a[1], a[0]};
    assign req_wdata = {d[3], d[2], d[1], d[0]};

    ram_port_arbiter #(.NUM_CORES(NC), .ADDR_W(32), .WORD_W(64), .LOCK_MAX(LOCK_MAX)) dut (
        .clk         (clk),
        .reset       (reset),
        .req_valid   (v),
        .req_we      (we),
        .req_addr    (req_addr),
        .req_wdata   (req_wdata),
`ifdef ARB_LOCK_EN
        .req_lock    (lk),
`endif
        .req_ready   (req_ready),
        .resp_valid  (resp_valid),
        .resp_rdata  (resp_rdata),
        .ram_address (ram_address),
        .ram_data    (ram_data),
        .ram_wren    (ram_wren),
        .ram_q       (ram_q)
    );

    always #5 clk = ~clk;

    function automatic logic [63:0] init_val(input logic [7:0] adr);
        return (adr == 8'h10) ? 64'hAB : 64'h0100 + 64'(adr);
    endfunction

    // RAM stand-in: registered read, write-through on write
    logic [63:0] bram [256];
    bit          bwr  [256];
    always @(posedge clk) begin
        if (ram_wren) begin
            bram[ram_address[7:0]] <= ram_data;
            bwr[ram_address[7:0]]  <= 1'b1;
            ram_q <= ram_data;
        end else begin
            ram_q <= bwr[ram_address[7:0]] ? bram[ram_address[7:0]] : init_val(ram_address[7:0]);
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: who wins, where the pointer goes, what comes back
    int          m_ptr = 0;
    bit          m_pend = 0;
    int          m_pend_id = 0;
    logic [63:0] m_pend_data = '0;
    int          m_owner = -1;
    int          m_run = 0;
    logic [63:0] m_mem [256];
    bit          m_wr  [256];
    int          exp_g;
    bit          exp_forced;

    function automatic int exp_grant(input logic [NC-1:0] vv, input int ptr, input int owner, input int run);
        if (owner >= 0 && run < LOCK_MAX && vv[owner]) return owner;
        for (int k = 0; k < NC; k++) begin
            if (vv[(ptr + k) % NC]) return (ptr + k) % NC;
        end
        return -1;
    endfunction

    always_comb begin
        exp_g      = exp_grant(v, m_ptr, m_owner, m_run);
        exp_forced = (m_owner >= 0) && (m_run < LOCK_MAX) && (exp_g == m_owner);
    end

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_ptr <= 0; m_pend <= 0; m_pend_id <= 0; m_owner <= -1; m_run <= 0;
        end else if (exp_g >= 0) begin
            m_pend    <= 1;
            m_pend_id <= exp_g;
            m_ptr     <= (exp_g + 1) % NC;
            if (we[exp_g]) begin
                m_mem[a[exp_g][7:0]] <= d[exp_g];
                m_wr[a[exp_g][7:0]]  <= 1'b1;
                m_pend_data <= d[exp_g];
            end else begin
                m_pend_data <= m_wr[a[exp_g][7:0]] ? m_mem[a[exp_g][7:0]] : init_val(a[exp_g][7:0]);
            end
`ifdef ARB_LOCK_EN
            if (lk[exp_g]) begin
                m_owner <= exp_g;
                m_run   <= exp_forced ? m_run + 1 : 1;
            end else begin
                m_owner <= -1;
                m_run   <= 0;
            end
`endif
        end else begin
            m_pend <= 0; m_owner <= -1; m_run <= 0;
        end
    end

    // Every-cycle comparison against the model
    always @(negedge clk) begin
        if (reset) begin
            chk("rst_resp_valid", 64'(resp_valid), 64'd0);
            chk("rst_ram_wren", 64'(ram_wren), 64'd0);
        end else begin
            if (exp_g >= 0) begin
                chk("m_req_ready", 64'(req_ready), 64'(4'b0001 << exp_g));
                chk("m_ram_wren", 64'(ram_wren), 64'(we[exp_g]));
                chk("m_ram_address", 64'(ram_address), 64'(a[exp_g]));
                chk("m_ram_data", ram_data, d[exp_g]);
            end else begin
                chk("m_req_ready_idle", 64'(req_ready), 64'd0);
                chk("m_ram_wren_idle", 64'(ram_wren), 64'd0);
                chk("m_ram_address_idle", 64'(ram_address), 64'd0);
            end
            chk("m_resp_valid", 64'(resp_valid), m_pend ? 64'(4'b0001 << m_pend_id) : 64'd0);
            if (m_pend) chk("m_resp_rdata", resp_rdata, m_pend_data);
        end
    end

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    logic [7:0] vec [6] = '{8'hA2, 8'h64, 8'hF9, 8'h10, 8'h88, 8'h55};

    initial begin
        for (int i = 0; i < NC; i++) begin a[i] = '0; d[i] = '0; end
        repeat (2) @(posedge clk);
        #1;
        @(negedge clk);
        chk("reset_resp_valid", 64'(resp_valid), 64'd0);
        chk("reset_ram_wren", 64'(ram_wren), 64'd0);
        next_cycle();
        reset = 1'b0;

        // Fairness straight out of reset: pointer starts at core 0
        v = 4'hF;
        for (int i = 0; i < NC; i++) a[i] = 32'(i * 8);
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            chk("fair_grant", 64'(req_ready), 64'(4'b0001 << (c % 4)));
            next_cycle();
        end

        // Reset while core 0's response is in flight
        v = 4'b0001; a[0] = 32'h10;
        @(negedge clk);
        chk("rst_pre_grant", 64'(req_ready), 64'h1);
        next_cycle();
        v = '0;
        #1 reset = 1'b1;
        @(negedge clk);
        chk("rst_mid_resp", 64'(resp_valid), 64'd0);
        next_cycle();
        reset = 1'b0;
        @(negedge clk);
        chk("rst_after_resp", 64'(resp_valid), 64'd0);
        next_cycle();

        // Single read: core 2 reads 0x10
        v = 4'b0100; a[2] = 32'h10;
        @(negedge clk);
        chk("rd_ready", 64'(req_ready), 64'h4);
        next_cycle();
        v = '0;
        @(negedge clk);
        chk("rd_resp_valid", 64'(resp_valid), 64'h4);
        chk("rd_resp_rdata", resp_rdata, 64'hAB);
        next_cycle();

        // Write acknowledge then read-back: core 1 writes 0x55 to 0x4
        v = 4'b0010; we = 4'b0010; a[1] = 32'h4; d[1] = 64'h55;
        @(negedge clk);
        chk("wr_ready", 64'(req_ready), 64'h2);
        chk("wr_wren", 64'(ram_wren), 64'h1);
        next_cycle();
        we = '0; d[1] = '0;
        @(negedge clk);
        chk("wr_ack_valid", 64'(resp_valid), 64'h2);
        chk("wr_ack_rdata", resp_rdata, 64'h55);
        next_cycle();
        v = '0;
        @(negedge clk);
        chk("rb_rdata", resp_rdata, 64'h55);
        next_cycle();

        // Idle stretch: no strobes, pointer holds at 2
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            chk("idle_wren", 64'(ram_wren), 64'd0);
            chk("idle_resp", 64'(resp_valid), 64'd0);
            next_cycle();
        end
        v = 4'hF;
        @(negedge clk);
        chk("idle_ptr_hold", 64'(req_ready), 64'h4);
        next_cycle();

`ifdef ARB_LOCK_EN
        // Core 3 holds its lock: LOCK_MAX grants, then round-robin resumes at core 0
        lk = 4'b1000;
        for (int c = 0; c < 9; c++) begin
            @(negedge clk);
            chk("lock_grant", 64'(req_ready), (c < 8) ? 64'h8 : 64'h1);
            next_cycle();
        end
        lk = '0;
`endif

        // Mixed read/write patterns on shared addresses
        for (int c = 0; c < 6; c++) begin
            v  = vec[c][7:4];
            we = vec[c][3:0];
            for (int i = 0; i < NC; i++) begin
                a[i] = 32'h20 + 32'(i % 2);
                d[i] = 64'hD000 + 64'(c * 16 + i);
            end
            next_cycle();
        end
        v = '0; we = '0;
        repeat (3) next_cycle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
